// File: rtl/store_buf_pkg.sv
// Shared definitions for the store buffer / store alignment path.
// Provides the access-size encodings, the drain FSM state type and a
// helper that turns an access size into a right-justified byte mask.
package store_buf_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } drain_state_t;

  // Right-justified byte mask covering one access of the given size.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] m;
    case (size)
      SZ_BYTE: m = 8'h01;
      SZ_HALF: m = 8'h03;
      SZ_WORD: m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sb_lane_align.sv
// Combinational lane alignment for stores (also used by the load-extract
// path). Places right-justified data onto the byte lanes selected by the
// low address bits and produces the matching byte strobes.
// Ports:
//   ofs        byte offset within the data word
//   size       access size encoding (byte/half/word/dword)
//   data       right-justified store data
//   wstrb      byte strobes for the aligned access
//   wdata      lane-aligned data
//   misaligned offset not a multiple of the size, or dword on a 32-bit bus
module sb_lane_align
  import store_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LANES = DATA_W / 8,
  localparam int OFS_W = $clog2(LANES)
) (
  input  logic [OFS_W-1:0]  ofs,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] data,
  output logic [LANES-1:0]  wstrb,
  output logic [DATA_W-1:0] wdata,
  output logic              misaligned
);

  logic [LANES-1:0] mask;
  logic [OFS_W-1:0] align_bits;
  logic             illegal_size;

  // The alignment check reuses the size mask shifted down by one: the
  // offset bits it covers must all be zero for a naturally aligned access.
  always_comb begin
    mask         = LANES'(size_mask(size));
    align_bits   = OFS_W'(size_mask(size) >> 1);
    illegal_size = (size == SZ_DWORD) && (DATA_W == 32);
    wstrb        = mask << ofs;
    wdata        = data << {ofs, 3'b000};
    misaligned   = illegal_size || ((ofs & align_bits) != '0);
  end

endmodule

// File: rtl/store_buffer_align.sv
// Store alignment and buffering between MEM stage and the data-side
// memory bridge. Aligned stores are queued in a DEPTH-entry FIFO and
// drained one at a time over a req/addr_ok/data_ok handshake; misaligned
// or illegal-size stores are accepted, dropped and reported via st_ades.
// Optional feature macro: STORE_BUF_MERGE_EN (merge same-line stores into
// the tail entry when that entry is not the one being drained).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   st_valid/st_ready          store request handshake
//   st_size/st_addr/st_data    store request fields (data right-justified)
//   st_ades/st_badvaddr        address-error pulse and faulting address
//   mem_req/mem_addr/          head entry presented to the bridge
//   mem_wstrb/mem_wdata
//   mem_addr_ok/mem_data_ok    bridge request accept / write complete
//   sb_count/sb_empty          buffer occupancy
module store_buffer_align
  import store_buf_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  localparam int LANES = DATA_W / 8,
  localparam int OFS_W = $clog2(LANES),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ades,
  output logic [ADDR_W-1:0] st_badvaddr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LANES-1:0]  mem_wstrb,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  output logic [CNT_W-1:0]  sb_count,
  output logic              sb_empty
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [LANES-1:0]  strb_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr, tail;
  logic [CNT_W-1:0]  count;
  drain_state_t      state;

  logic [LANES-1:0]  al_wstrb;
  logic [DATA_W-1:0] al_wdata;
  logic              al_mis;
  logic [ADDR_W-1:0] line_addr;
  logic              full, fire, merge_hit, enq, pop, remaining;

  sb_lane_align #(.DATA_W(DATA_W)) u_align (
    .ofs       (st_addr[OFS_W-1:0]),
    .size      (st_size),
    .data      (st_data),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .misaligned(al_mis)
  );

  // Handshake and queue-control decode. Fullness comes from the registered
  // count, so a pop in the same cycle never opens a slot early. A merge
  // may only target the tail when that tail is not the entry currently
  // presented to or owned by the bridge.
  always_comb begin
    line_addr = {st_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
    tail      = wr_ptr - PTR_W'(1);
    full      = (count == CNT_W'(DEPTH));
`ifdef STORE_BUF_MERGE_EN
    merge_hit = (count != '0) && !al_mis && (addr_q[tail] == line_addr) &&
                !((tail == rd_ptr) && (state != S_IDLE));
    st_ready  = !full || merge_hit;
`else
    merge_hit = 1'b0;
    st_ready  = !full;
`endif
    fire      = st_valid && st_ready;
    enq       = fire && !al_mis && !merge_hit;
    pop       = ((state == S_REQ) && mem_addr_ok && mem_data_ok) ||
                ((state == S_WAIT) && mem_data_ok);
    remaining = (count > CNT_W'(1)) || enq;
  end

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH
  // is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(enq) - CNT_W'(pop);
    end
  end

  // Entry storage. A merge overwrites only the lanes the new store selects
  // and accumulates strobes so earlier bytes in the line are preserved.
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[wr_ptr] <= line_addr;
      strb_q[wr_ptr] <= al_wstrb;
      data_q[wr_ptr] <= al_wdata;
    end else if (fire && merge_hit) begin
      strb_q[tail] <= strb_q[tail] | al_wstrb;
      for (int i = 0; i < LANES; i++) begin
        if (al_wstrb[i]) data_q[tail][8*i +: 8] <= al_wdata[8*i +: 8];
      end
    end
  end

  // Address-error reporting: one-cycle pulse after the faulting handshake,
  // with the faulting address held until the next fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_ades     <= 1'b0;
      st_badvaddr <= '0;
    end else begin
      st_ades <= fire && al_mis;
      if (fire && al_mis) st_badvaddr <= st_addr;
    end
  end

  // Drain FSM. Only one write is outstanding; addr_ok and data_ok together
  // in REQ complete the whole transfer at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (count != '0) state <= S_REQ;
        S_REQ: begin
          if (mem_addr_ok) begin
            if (mem_data_ok) state <= remaining ? S_REQ : S_IDLE;
            else             state <= S_WAIT;
          end
        end
        S_WAIT: if (mem_data_ok) state <= remaining ? S_REQ : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Head fields are shown only while requesting; the head entry cannot be
  // modified once the FSM has left IDLE, so they stay stable in REQ.
  always_comb begin
    mem_req   = (state == S_REQ);
    mem_addr  = mem_req ? addr_q[rd_ptr] : '0;
    mem_wstrb = mem_req ? strb_q[rd_ptr] : '0;
    mem_wdata = mem_req ? data_q[rd_ptr] : '0;
    sb_count  = count;
    sb_empty  = (count == '0);
  end

endmodule
